// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and FSM encoding for the AES round key sequencer.
package aes_pkg;
    localparam int NR = 10;
    localparam int KEY_BYTES = 16;
    localparam int SCHED_BYTES = (NR + 1) * KEY_BYTES;
    localparam logic [7:0] LAST_ADDR = 8'(SCHED_BYTES - 1);
    localparam logic [3:0] MAX_ROUND = 4'(NR);
    localparam logic [3:0] AUTO_ROUND = 4'hF;
    typedef enum logic [1:0] {IDLE, CAPTURE, READY, STREAM} state_t;
endpackage

// File: rtl/aes_round_key_sequencer_if.sv
// aes_round_key_sequencer_if: key expansion byte feed plus encrypt-core round key handshake.
interface aes_round_key_sequencer_if;
    logic       key_start;
    logic       ke_byte_valid;
    logic [7:0] ke_byte;
    logic       enc_req;
    logic [3:0] enc_round;
    logic [7:0] rk_byte;
    logic       rk_valid;
    logic       rk_last;
    logic       keys_ready;
    logic       busy;
    logic       err;
    modport master (
        output key_start, ke_byte_valid, ke_byte, enc_req, enc_round,
        input  rk_byte, rk_valid, rk_last, keys_ready, busy, err
    );
    modport slave (
        input  key_start, ke_byte_valid, ke_byte, enc_req, enc_round,
        output rk_byte, rk_valid, rk_last, keys_ready, busy, err
    );
endinterface

// File: rtl/aes_rk_mem.sv
// aes_rk_mem: 176x8 round key store with synchronous write and registered read.
module aes_rk_mem
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [7:0] wa,
    input  logic [7:0] wd,
    input  logic       re,
    input  logic [7:0] ra,
    output logic [7:0] rd
);
    logic [7:0] mem [SCHED_BYTES];
    always_ff @(posedge clk)
        if (we) mem[wa] <= wd;
    // Only the read register is reset; the array contents are left undefined.
    always_ff @(posedge clk or posedge rst)
        if (rst) rd <= '0;
        else if (re) rd <= mem[ra];
endmodule

// File: rtl/aes_round_key_sequencer.sv
// aes_round_key_sequencer: captures the 176-byte key schedule and replays round keys on request.
// Optional macro AES_RK_AUTOSEQ_EN: enc_round=4'hF streams all rounds back-to-back.
module aes_round_key_sequencer
    import aes_pkg::*;
(
    input logic clk,
    input logic rst,
    aes_round_key_sequencer_if.slave bus
);
`ifdef AES_RK_AUTOSEQ_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif
    state_t state, state_nxt;
    logic [7:0] cap_cnt, ptr, start, rd_addr, rk_q;
    logic auto_mode, auto_req, round_ok, at_end, window;
    logic accept, reject, rd_en, wr_en, err_q;
    always_comb begin
        auto_req = AUTO_EN && bus.enc_round == AUTO_ROUND;
        round_ok = bus.enc_round <= MAX_ROUND || auto_req;
        at_end = state == STREAM && (auto_mode ? ptr == LAST_ADDR : ptr[3:0] == 4'hF);
        window = state == READY || at_end;
        accept = bus.enc_req && !bus.key_start && window && round_ok;
        reject = bus.enc_req && !bus.key_start &&
                 (state == IDLE || state == CAPTURE || (window && !round_ok));
        start = auto_req ? 8'h00 : {bus.enc_round, 4'h0};
        wr_en = state == CAPTURE && bus.ke_byte_valid && !bus.key_start;
        // Read address runs one byte ahead of the byte on rk_byte.
        rd_en = accept || (state == STREAM && !at_end && !bus.key_start);
        rd_addr = accept ? start : ptr + 8'd1;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        if (bus.key_start) state_nxt = CAPTURE;
        else if (wr_en && cap_cnt == LAST_ADDR) state_nxt = READY;
        else if (accept) state_nxt = STREAM;
        else if (at_end) state_nxt = READY;
    end
    always_comb begin
        bus.rk_byte = rk_q;
        bus.rk_valid = state == STREAM;
        bus.rk_last = state == STREAM && ptr[3:0] == 4'hF;
        bus.keys_ready = state == READY || state == STREAM;
        bus.busy = state == CAPTURE || state == STREAM;
        bus.err = err_q;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cap_cnt <= '0;
            ptr <= '0;
            auto_mode <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= reject;
            cap_cnt <= bus.key_start ? 8'd0 : wr_en ? cap_cnt + 8'd1 : cap_cnt;
            if (accept) begin
                ptr <= start;
                auto_mode <= auto_req;
            end else if (rd_en) ptr <= rd_addr;
        end
    aes_rk_mem u_mem (
        .clk(clk),
        .rst(rst),
        .we(wr_en),
        .wa(cap_cnt),
        .wd(bus.ke_byte),
        .re(rd_en),
        .ra(rd_addr),
        .rd(rk_q)
    );
endmodule

// File: doc/aes_round_key_sequencer.md
Name: aes_round_key_sequencer

Overview:
- Buffers the 176 bytes (11 round keys) produced byte-serially by the 8-bit key expansion datapath.
- Replays any requested round key to the byte-serial encryption datapath on demand, 16 bytes per request, MSB byte first.
- Sits between the key expansion unit and the encrypt core.
- Replaces free-running cycle-count timing with an explicit request/valid handshake.

Parameters:
- NR, 10, number of AES rounds; storage holds NR+1 round keys (fixed at 10 for AES-128).
- KEY_BYTES, 16, bytes per round key.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- key_start  input  1  pulse; begin capture of a fresh key schedule.
- ke_byte_valid  input  1  key expansion byte strobe.
- ke_byte  input  8  key expansion output byte.
- enc_req  input  1  encrypt core requests a round key.
- enc_round  input  4  requested round index, 0..NR.
- rk_byte  output  8  round key byte to encrypt core.
- rk_valid  output  1  rk_byte valid.
- rk_last  output  1  marks the 16th byte of a round key.
- keys_ready  output  1  all NR+1 round keys are stored.
- busy  output  1  capturing or streaming.
- err  output  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0. The key storage array (176x8) is not reset.
- FSM states: IDLE, CAPTURE, READY, STREAM.
- IDLE -> CAPTURE on key_start.
- CAPTURE:
  - Each cycle with ke_byte_valid=1 writes ke_byte to mem[cap_cnt] and increments cap_cnt (8-bit, 0..175).
  - Byte k of round r is stored at address 16r+k; byte 0 is key bits [127:120].
  - When byte 175 is written, go to READY; keys_ready=1 the following cycle.
- READY: on enc_req with enc_round<=NR:
  - Latch the round and go to STREAM.
  - rk_valid=1 from the next cycle for exactly 16 consecutive cycles, byte 0 first. First byte appears 1 cycle after acceptance.
  - rk_last=1 together with byte 15.
- STREAM -> READY after byte 15.
  - If enc_req is high in the rk_last cycle with a valid round, the next stream starts immediately with no bubble.
  - enc_req on any other STREAM cycle is ignored; no queueing, no err.
- Rejected requests (err pulses 1 cycle, no state change):
  - enc_round>NR in READY, or in the rk_last cycle.
  - enc_req in IDLE or CAPTURE.
- key_start in any state:
  - Clears keys_ready and rk_valid next cycle, resets cap_cnt, enters CAPTURE. Any stream in progress is aborted.
  - key_start wins over a simultaneous enc_req; no err is raised.
- ke_byte_valid outside CAPTURE is ignored.
- busy=1 in CAPTURE and STREAM.
- rk_byte holds its last value when rk_valid=0.
- Asynchronous rst mid-capture or mid-stream returns to IDLE immediately. keys_ready=0, so stale memory is never streamed.

Optional Feature:
- Macro: AES_RK_AUTOSEQ_EN.
- Defined: enc_round=4'hF in READY is accepted as an auto-sequence. All rounds 0..NR stream back-to-back (176 consecutive rk_valid cycles), with rk_last after every 16th byte. enc_req during auto-sequence is ignored. key_start aborts it.
- Undefined: 4'hF is out of range and raises err.

Decomposition:
- Shared package aes_pkg holds:
  - NR and KEY_BYTES constants.
  - SCHED_BYTES=176 constant.
  - FSM state typedef/encodings (IDLE, CAPTURE, READY, STREAM).
  - AUTO_ROUND=4'hF constant.
- One sub-module is natural: aes_rk_mem, a 176x8 synchronous-write, registered-read memory. The sequencer issues the read address one cycle ahead, which gives the 1-cycle latency.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, expansion bytes fed with key_start -> keys_ready rises 1 cycle after byte 175; busy falls.
- enc_req, enc_round=1 -> 16 bytes a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05 starting next cycle; rk_last on 05.
- Round 10 requested, then round 0 requested in the rk_last cycle -> d014f9a8c9ee2589e13f0cc8b6630ca6 immediately followed by 2b7e...4f3c, with no bubble.
- Error cases, each checked for no state change:
  - enc_round=11 in READY -> err one cycle, no rk_valid.
  - enc_req during CAPTURE -> err.
- key_start at byte 7 of a stream -> rk_valid drops next cycle; keys_ready=0; recapture of a new key then streams the new values.
- rst asserted mid-capture (byte 90), asynchronously between edges -> outputs 0 immediately. A later enc_req gets err. With AES_RK_AUTOSEQ_EN, enc_round=F after a full capture -> 176 bytes with 11 rk_last pulses.
